// File: rtl/mul_operand_sequencer.sv
// rtl/mul_operand_sequencer.sv - operand capture, start issue and product hand-off for the multiplier core
//
// Purpose: takes A then B as two consecutive transfers on the shared operand bus,
// pulses mul_start to the core for one cycle, captures the core's full-width
// product and holds it behind a valid/ready handshake. One operation in flight.
//
// Optional feature macro: MUL_SEQ_TIMEOUT_EN
//   defined   - WAIT aborts after TIMEOUT cycles without mul_done: the output is
//               presented as zero with err_o set; err_o clears on the handshake.
//   undefined - no counter; err_o is constant 0 and WAIT waits indefinitely.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   in_valid/in_data/in_ready operand input (1st transfer A, 2nd B)
//   a_o, b_o, mul_start       registered operands and start pulse to the core
//   mul_done, product_i       result strobe and product from the core
//   out_valid/out_data/out_ready  captured product to the consumer
//   busy                      any state other than IDLE
//   err_o                     operation aborted by timeout
module mul_operand_sequencer #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic                 mul_start,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   product_i,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_B = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_timeout;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_mul_start;
    logic                   r_out_valid;
    logic [2*WIDTH-1:0]     r_out_data;

`ifdef MUL_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]          r_cnt;
    logic                   r_err;

    // Cleared during ISSUE so it reads 0 in the first WAIT cycle; the value
    // therefore equals the number of WAIT cycles already completed.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Expiry only matters when mul_done is absent; the datapath checks
    // mul_done first so a coincident result wins.
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_err <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (mul_done) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end else if (r_state == S_HOLD && out_ready) begin
            r_err <= 1'b0;
        end
    end

    assign err_o = r_err;
`else
    // TIMEOUT is inert without the counter; this comparison is constant false.
    assign w_timeout = (TIMEOUT < 0);
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)              w_next = S_GET_B;
            S_GET_B: if (in_valid)              w_next = S_ISSUE;
            S_ISSUE:                            w_next = S_WAIT;
            S_WAIT:  if (mul_done || w_timeout) w_next = S_HOLD;
            S_HOLD:  if (out_ready)             w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mul_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            // Set on the edge that accepts B, so the pulse covers exactly the ISSUE cycle.
            r_mul_start <= (r_state == S_GET_B) && in_valid;
            case (r_state)
                S_IDLE: if (in_valid) r_a <= in_data;
                S_GET_B: if (in_valid) r_b <= in_data;
                S_WAIT: begin
                    if (mul_done) begin
                        r_out_data  <= product_i;
                        r_out_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_out_data  <= '0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_HOLD: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) || (r_state == S_GET_B);
    assign busy      = (r_state != S_IDLE);
    assign a_o       = r_a;
    assign b_o       = r_b;
    assign mul_start = r_mul_start;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
